// File: rtl/trace_pkg.sv
// Shared types for the retire trace sink: FSM states, the buffered record,
// FLAGS bit positions and packet lengths.
package trace_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_FLAGS, S_PC, S_INSTR, S_RD, S_RDDATA, S_MADDR, S_MDATA
  } trace_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  reg_addr;
    logic [31:0] reg_data;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic        mem_wrt;
  } trace_rec_t;

  localparam int FLG_REG = 0;
  localparam int FLG_MEM = 1;

  localparam int PKT_LEN_BASE = 9;
  localparam int PKT_LEN_REG  = 14;
  localparam int PKT_LEN_MEM  = 17;
  localparam int PKT_LEN_ALL  = 22;

  function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] i);
    return w[{i, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous record FIFO; pointers carry a wrap bit to tell full from empty.
module trace_fifo
  import trace_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic       push_i,
  input  logic       pop_i,
  input  trace_rec_t data_i,
  output trace_rec_t data_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wptr_q, rptr_q;
  trace_rec_t  mem_q [DEPTH];

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push_i) wptr_q <= wptr_q + 1'b1;
      if (pop_i)  rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wptr_q[AW-1:0]] <= data_i;
  end

  assign data_o  = mem_q[rptr_q[AW-1:0]];
  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

endmodule

// File: rtl/retire_trace_sink.sv
// Buffers retire records and streams each as a little-endian byte packet
// over valid/ready; keeps retire/drop counters for lost-trace detection.
module retire_trace_sink
  import trace_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 8
) (
  input  logic            clk_i,
  input  logic            rstn_i,
  input  logic            retire_valid_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [31:0]     instr_i,
  input  logic [4:0]      reg_addr_i,
  input  logic [XLEN-1:0] reg_data_i,
  input  logic [XLEN-1:0] mem_addr_i,
  input  logic [XLEN-1:0] mem_data_i,
  input  logic            mem_wrt_i,
  output logic            tx_valid_o,
  output logic [7:0]      tx_data_o,
  input  logic            tx_ready_i,
  output logic [31:0]     retire_cnt_o,
  output logic [15:0]     drop_cnt_o,
  output logic            overflow_o,
  output logic            empty_o
);

  trace_state_e state_q, state_d;
  logic [1:0]   idx_q, idx_d;
  trace_rec_t   rec_q, fifo_rec, in_rec;
  logic         fifo_full, fifo_empty, push, pop, drop, hs, pkt_end;
  logic         flg_reg, flg_mem;
  logic [31:0]  retire_cnt_q;
  logic [15:0]  drop_cnt_q;
  logic         overflow_q;

  assign in_rec = '{pc: pc_i, instr: instr_i, reg_addr: reg_addr_i, reg_data: reg_data_i,
                    mem_addr: mem_addr_i, mem_data: mem_data_i, mem_wrt: mem_wrt_i};

  // A full FIFO still accepts a push when the same edge pops.
  assign push = retire_valid_i & (~fifo_full | pop);
  assign drop = retire_valid_i & fifo_full & ~pop;
  assign pop  = ~fifo_empty & ((state_q == S_IDLE) | pkt_end);

  trace_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (in_rec),
    .data_o  (fifo_rec),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign flg_reg    = (rec_q.reg_addr != 5'd0);
  assign flg_mem    = rec_q.mem_wrt;
  assign tx_valid_o = (state_q != S_IDLE);
  assign hs         = tx_valid_o & tx_ready_i;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pkt_end = 1'b0;
    case (state_q)
      S_IDLE:   if (!fifo_empty) state_d = S_FLAGS;
      S_FLAGS:  if (hs) state_d = S_PC;
      S_PC:     if (hs) begin
                  idx_d = idx_q + 2'd1;
                  if (idx_q == 2'd3) state_d = S_INSTR;
                end
      S_INSTR:  if (hs) begin
                  idx_d = idx_q + 2'd1;
                  if (idx_q == 2'd3) begin
                    if (flg_reg)      state_d = S_RD;
                    else if (flg_mem) state_d = S_MADDR;
                    else              pkt_end = 1'b1;
                  end
                end
      S_RD:     if (hs) state_d = S_RDDATA;
      S_RDDATA: if (hs) begin
                  idx_d = idx_q + 2'd1;
                  if (idx_q == 2'd3) begin
                    if (flg_mem) state_d = S_MADDR;
                    else         pkt_end = 1'b1;
                  end
                end
      S_MADDR:  if (hs) begin
                  idx_d = idx_q + 2'd1;
                  if (idx_q == 2'd3) state_d = S_MDATA;
                end
      S_MDATA:  if (hs) begin
                  idx_d = idx_q + 2'd1;
                  if (idx_q == 2'd3) pkt_end = 1'b1;
                end
      default:  state_d = S_IDLE;
    endcase
    // Chain straight into the next packet so a busy stream has no bubble.
    if (pkt_end) state_d = fifo_empty ? S_IDLE : S_FLAGS;
  end

  always_comb begin
    tx_data_o = 8'h00;
    case (state_q)
      S_FLAGS:  tx_data_o = {6'b0, flg_mem, flg_reg};
      S_PC:     tx_data_o = byte_of(rec_q.pc, idx_q);
      S_INSTR:  tx_data_o = byte_of(rec_q.instr, idx_q);
      S_RD:     tx_data_o = {3'b0, rec_q.reg_addr};
      S_RDDATA: tx_data_o = byte_of(rec_q.reg_data, idx_q);
      S_MADDR:  tx_data_o = byte_of(rec_q.mem_addr, idx_q);
      S_MDATA:  tx_data_o = byte_of(rec_q.mem_data, idx_q);
      default:  tx_data_o = 8'h00;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q      <= S_IDLE;
      idx_q        <= 2'd0;
      rec_q        <= '0;
      retire_cnt_q <= '0;
      drop_cnt_q   <= '0;
      overflow_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (pop) rec_q <= fifo_rec;
      if (retire_valid_i) retire_cnt_q <= retire_cnt_q + 32'd1;
      if (drop && drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
      if (drop) overflow_q <= 1'b1;
    end
  end

  assign retire_cnt_o = retire_cnt_q;
  assign drop_cnt_o   = drop_cnt_q;
  assign overflow_o   = overflow_q;
  assign empty_o      = fifo_empty & (state_q == S_IDLE);

endmodule

// File: tb/tb_retire_trace_sink.sv
// Directed bench for retire_trace_sink: packet contents, latency, back-to-back,
// backpressure, overflow accounting and mid-packet reset.
module tb_retire_trace_sink;
  import trace_pkg::*;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic        retire_valid_i;
  logic [31:0] pc_i, instr_i, reg_data_i, mem_addr_i, mem_data_i;
  logic [4:0]  reg_addr_i;
  logic        mem_wrt_i;
  logic        tx_valid_o, tx_ready_i;
  logic [7:0]  tx_data_o;
  logic [31:0] retire_cnt_o;
  logic [15:0] drop_cnt_o;
  logic        overflow_o, empty_o;

  retire_trace_sink #(.XLEN(32), .DEPTH(8)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .retire_valid_i(retire_valid_i),
    .pc_i(pc_i), .instr_i(instr_i), .reg_addr_i(reg_addr_i), .reg_data_i(reg_data_i),
    .mem_addr_i(mem_addr_i), .mem_data_i(mem_data_i), .mem_wrt_i(mem_wrt_i),
    .tx_valid_o(tx_valid_o), .tx_data_o(tx_data_o), .tx_ready_i(tx_ready_i),
    .retire_cnt_o(retire_cnt_o), .drop_cnt_o(drop_cnt_o),
    .overflow_o(overflow_o), .empty_o(empty_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0, n_bad = 0;
  int ncyc = 0, ret_edge = 0, rdy_mode = 0;
  bit hold_en = 0;
  logic [7:0] rx_q[$], exp_q[$];
  int rx_cyc[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Byte capture at the falling edge: valid&ready here means the next rising edge hands off.
  always @(negedge clk_i) begin
    ncyc++;
    if (hold_en && tx_valid_o && !tx_ready_i && rx_q.size() < exp_q.size())
      chk("hold", tx_data_o, exp_q[rx_q.size()]);
    if (tx_valid_o && tx_ready_i) begin
      rx_q.push_back(tx_data_o);
      rx_cyc.push_back(ncyc);
    end
  end

  initial begin
    tx_ready_i = 1'b1;
    forever begin
      @(posedge clk_i); #1;
      case (rdy_mode)
        0:       tx_ready_i = 1'b1;
        1:       tx_ready_i = 1'($urandom_range(0, 1));
        default: tx_ready_i = 1'b0;
      endcase
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  function automatic trace_rec_t mkrec(input logic [31:0] pc, input logic [31:0] ins,
      input logic [4:0] rd, input logic [31:0] rdat, input logic [31:0] ma,
      input logic [31:0] md, input logic mw);
    trace_rec_t r;
    r.pc = pc; r.instr = ins; r.reg_addr = rd; r.reg_data = rdat;
    r.mem_addr = ma; r.mem_data = md; r.mem_wrt = mw;
    return r;
  endfunction

  // Reference packet builder straight from the byte-order description.
  function automatic void add_pkt(input trace_rec_t r);
    exp_q.push_back({6'b0, r.mem_wrt, r.reg_addr != 5'd0});
    for (int i = 0; i < 4; i++) exp_q.push_back(r.pc[8*i +: 8]);
    for (int i = 0; i < 4; i++) exp_q.push_back(r.instr[8*i +: 8]);
    if (r.reg_addr != 5'd0) begin
      exp_q.push_back({3'b0, r.reg_addr});
      for (int i = 0; i < 4; i++) exp_q.push_back(r.reg_data[8*i +: 8]);
    end
    if (r.mem_wrt) begin
      for (int i = 0; i < 4; i++) exp_q.push_back(r.mem_addr[8*i +: 8]);
      for (int i = 0; i < 4; i++) exp_q.push_back(r.mem_data[8*i +: 8]);
    end
  endfunction

  task automatic retire(input trace_rec_t r);
    retire_valid_i = 1'b1;
    pc_i = r.pc; instr_i = r.instr; reg_addr_i = r.reg_addr; reg_data_i = r.reg_data;
    mem_addr_i = r.mem_addr; mem_data_i = r.mem_data; mem_wrt_i = r.mem_wrt;
    @(posedge clk_i); #1;
    retire_valid_i = 1'b0;
    ret_edge = ncyc + 1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk_i); #1; end
  endtask

  task automatic wait_bytes(input int n, input int budget);
    int k = 0;
    while (rx_q.size() < n && k < budget) begin @(posedge clk_i); k++; end
    #1;
    chk("byte_wait", rx_q.size() >= n, 1);
  endtask

  task automatic clr();
    rx_q.delete(); rx_cyc.delete(); exp_q.delete();
  endtask

  task automatic cmp_stream(input string tag);
    chk({tag, "_len"}, rx_q.size(), exp_q.size());
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++)
      chk($sformatf("%s_b%0d", tag, i), rx_q[i], exp_q[i]);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_valid"}, tx_valid_o, 0);
    chk({tag, "_data"}, tx_data_o, 0);
    chk({tag, "_rcnt"}, retire_cnt_o, 0);
    chk({tag, "_dcnt"}, drop_cnt_o, 0);
    chk({tag, "_ovf"}, overflow_o, 0);
    chk({tag, "_empty"}, empty_o, 1);
  endtask

  task automatic do_reset();
    rstn_i = 1'b0;
    idle(2);
    rstn_i = 1'b1;
    idle(1);
  endtask

  logic [7:0] alu_b [14] = '{8'h01, 8'h00, 8'h01, 8'h00, 8'h00, 8'h93, 8'h00, 8'h50,
                             8'h00, 8'h01, 8'h05, 8'h00, 8'h00, 8'h00};
  logic [7:0] st_b [17]  = '{8'h02, 8'h04, 8'h01, 8'h00, 8'h00, 8'h23, 8'h20, 8'hF1,
                             8'h00, 8'h00, 8'h20, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
  logic [7:0] br_b [18]  = '{8'h00, 8'h08, 8'h01, 8'h00, 8'h00, 8'h63, 8'h84, 8'h20, 8'h00,
                             8'h00, 8'h0C, 8'h01, 8'h00, 8'h00, 8'h63, 8'h84, 8'h20, 8'h00};

  initial begin
    trace_rec_t r;
    int k;
    rstn_i = 1'b0; retire_valid_i = 1'b0;
    pc_i = '0; instr_i = '0; reg_addr_i = '0; reg_data_i = '0;
    mem_addr_i = '0; mem_data_i = '0; mem_wrt_i = 1'b0;
    #2;
    chk_reset_vals("por");
    @(posedge clk_i); @(posedge clk_i); #1;
    rstn_i = 1'b1;
    idle(2);

    // ALU retire, 14 bytes, FLAGS one cycle after the sampling edge's successor
    clr();
    retire(mkrec(32'h100, 32'h00500093, 5'd1, 32'd5, 32'h0, 32'h0, 1'b0));
    k = ret_edge;
    wait_bytes(14, 60);
    idle(3);
    chk("alu_len", rx_q.size(), 14);
    for (int i = 0; i < 14 && i < rx_q.size(); i++) chk($sformatf("alu_b%0d", i), rx_q[i], alu_b[i]);
    if (rx_cyc.size() > 0) chk("alu_lat", rx_cyc[0] - k, 1);
    chk("alu_empty", empty_o, 1);
    chk("alu_rcnt", retire_cnt_o, 1);

    // Store, rd=0 so reg_data must not appear
    clr();
    retire(mkrec(32'h104, 32'h00F12023, 5'd0, 32'h55, 32'h2000, 32'hDEADBEEF, 1'b1));
    wait_bytes(17, 60);
    idle(3);
    chk("st_len", rx_q.size(), 17);
    for (int i = 0; i < 17 && i < rx_q.size(); i++) chk($sformatf("st_b%0d", i), rx_q[i], st_b[i]);

    // Two back-to-back branches: 9-byte packets with no gap
    clr();
    retire(mkrec(32'h108, 32'h00208463, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0));
    retire(mkrec(32'h10C, 32'h00208463, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0));
    wait_bytes(18, 60);
    idle(3);
    chk("br_len", rx_q.size(), 18);
    for (int i = 0; i < 18 && i < rx_q.size(); i++) chk($sformatf("br_b%0d", i), rx_q[i], br_b[i]);
    for (int i = 1; i < rx_cyc.size(); i++) chk($sformatf("br_gap%0d", i), rx_cyc[i] - rx_cyc[i-1], 1);
    chk("br_rcnt", retire_cnt_o, 4);

    // Backpressure over 20 mixed records, in batches of 4
    clr();
    rdy_mode = 1; hold_en = 1;
    for (int b = 0; b < 5; b++) begin
      for (int j = 0; j < 4; j++) begin
        int i;
        i = b * 4 + j;
        r = mkrec(32'h1000 + 4 * i, 32'h13 + 32'h100 * i, (i % 3 == 0) ? 5'd0 : 5'(i + 1),
                  32'h01010101 * i, 32'h3000 + 4 * i, 32'hA5A50000 + i, 1'(i % 2));
        add_pkt(r);
        retire(r);
      end
      wait_bytes(exp_q.size(), 600);
    end
    rdy_mode = 0; hold_en = 0;
    idle(3);
    cmp_stream("bp");
    chk("bp_drop", drop_cnt_o, 0);

    // Overflow: sink stalled, 10 retires. The first is popped into the output
    // register, eight fill the FIFO, the tenth is dropped.
    do_reset();
    clr();
    rdy_mode = 2;
    idle(1);
    for (int i = 0; i < 10; i++) begin
      r = mkrec(32'h200 + 4 * i, 32'h00000013, 5'(i % 2), 32'h100 + i, 32'h0, 32'h0, 1'b0);
      if (i < 9) add_pkt(r);
      retire(r);
    end
    idle(2);
    chk("ovf_drop", drop_cnt_o, 1);
    chk("ovf_flag", overflow_o, 1);
    chk("ovf_rcnt", retire_cnt_o, 10);
    chk("ovf_valid", tx_valid_o, 1);
    chk("ovf_stall_byte", tx_data_o, exp_q[0]);
    rdy_mode = 0;
    wait_bytes(exp_q.size(), 400);
    idle(5);
    cmp_stream("ovf");
    chk("ovf_empty", empty_o, 1);

    // Reset right after the 5th byte of a 22-byte packet
    do_reset();
    clr();
    r = mkrec(32'h400, 32'h00A12023, 5'd7, 32'hCAFEF00D, 32'h4000, 32'h12345678, 1'b1);
    add_pkt(r);
    chk("full_len_model", exp_q.size(), PKT_LEN_ALL);
    retire(r);
    k = 0;
    while (rx_q.size() < 5 && k < 50) begin @(posedge clk_i); k++; end
    #1;
    rstn_i = 1'b0;
    #1;
    chk_reset_vals("mid");
    chk("mid_bytes", rx_q.size(), 5);
    idle(2);
    rstn_i = 1'b1;
    idle(5);
    chk("mid_quiet_bytes", rx_q.size(), 5);
    chk("mid_quiet_valid", tx_valid_o, 0);
    clr();
    r = mkrec(32'h500, 32'h00B12223, 5'd9, 32'h0BADBEEF, 32'h5004, 32'h87654321, 1'b1);
    add_pkt(r);
    retire(r);
    wait_bytes(22, 60);
    idle(3);
    cmp_stream("post");
    chk("post_rcnt", retire_cnt_o, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
